output_buffer_3x3: RTL and testbench

- On-chip feature-map buffer placed between a convolution layer's output and the next 3x3 convolution layer.
- Stores one OUT_CHANNELS-deep feature map in zero-padded layout, (IN_HEIGHT+2) x (IN_WIDTH+2) pixels.
- Accepts one scalar write per cycle.
- Returns a full 3x3 x OUT_CHANNELS window in a single registered read, centred on an unpadded pixel.

---
 rtl/output_buffer_3x3.sv | 70 +++++++
 tb/tb_output_buffer_3x3.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_buffer_3x3.sv
// Feature-map buffer holding one zero-padded OUT_CHANNELS-deep map and serving
// a whole 3x3 x OUT_CHANNELS window per registered read.
module output_buffer_3x3 #(
    parameter int DATA_WIDTH   = 8,
    parameter int OUT_CHANNELS = 3,
    parameter int IN_WIDTH     = 5,
    parameter int IN_HEIGHT    = 5,
    localparam int PAD_WIDTH     = IN_WIDTH + 2,
    localparam int PAD_HEIGHT    = IN_HEIGHT + 2,
    localparam int DEPTH         = PAD_WIDTH * PAD_HEIGHT * OUT_CHANNELS,
    localparam int RD_ADDR_WIDTH = $clog2(IN_WIDTH * IN_HEIGHT),
    localparam int WR_ADDR_WIDTH = $clog2(DEPTH),
    localparam int RD_DATA_WIDTH = 9 * DATA_WIDTH * OUT_CHANNELS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WR_ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     is_padding,
    input  logic                     rd_en,
    input  logic [RD_ADDR_WIDTH-1:0] rd_addr,
    output logic [RD_DATA_WIDTH-1:0] rd_data
);

    // Register array rather than RAM: every window element is read in parallel.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [RD_DATA_WIDTH-1:0] window;
    logic                     rd_valid;
    int                       row;
    int                       col;
    int                       src;

    // Contents deliberately survive reset; the writer owns the padding border.
    always_ff @(posedge clk) begin
        if (!rst && wr_en && (int'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= is_padding ? '0 : wr_data;
        end
    end

    always_comb begin
        window   = '0;
        src      = 0;
        rd_valid = int'(rd_addr) < (IN_WIDTH * IN_HEIGHT);
        row      = int'(rd_addr) / IN_WIDTH;
        col      = int'(rd_addr) % IN_WIDTH;
        for (int ky = 0; ky < 3; ky++) begin
            for (int kx = 0; kx < 3; kx++) begin
                for (int c = 0; c < OUT_CHANNELS; c++) begin
                    src = ((row + ky) * PAD_WIDTH + col + kx) * OUT_CHANNELS + c;
                    if (src < DEPTH) begin
                        window[((ky * 3 + kx) * OUT_CHANNELS + c) * DATA_WIDTH +: DATA_WIDTH] =
                            mem[WR_ADDR_WIDTH'(src)];
                    end
                end
            end
        end
    end

    // The window is sampled before a same-edge write lands, giving read-before-write.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_valid ? window : '0;
        end
    end

endmodule

// File: tb/tb_output_buffer_3x3.sv
// Scoreboard bench for output_buffer_3x3: a byte-level model of the padded map
// predicts every window read, plus hand-computed spot values.
module tb_output_buffer_3x3;

    localparam int DW    = 8;
    localparam int OC    = 3;
    localparam int IW    = 5;
    localparam int IH    = 5;
    localparam int PW    = IW + 2;
    localparam int PH    = IH + 2;
    localparam int DEPTH = PW * PH * OC;
    localparam int RAW   = 5;
    localparam int WAW   = 8;
    localparam int RDW   = 9 * DW * OC;

    logic           clk = 1'b0;
    logic           rst;
    logic           wr_en;
    logic [WAW-1:0] wr_addr;
    logic [DW-1:0]  wr_data;
    logic           is_padding;
    logic           rd_en;
    logic [RAW-1:0] rd_addr;
    logic [RDW-1:0] rd_data;

    logic [DW-1:0]  model_mem [DEPTH];
    logic [RDW-1:0] sb_q [$];
    logic [RDW-1:0] exp_win;
    logic [RDW-1:0] held;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    output_buffer_3x3 #(
        .DATA_WIDTH(DW), .OUT_CHANNELS(OC), .IN_WIDTH(IW), .IN_HEIGHT(IH)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .is_padding(is_padding), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    function automatic logic [RDW-1:0] model_window(input int addr);
        logic [RDW-1:0] w;
        int r, c0, src;
        w = '0;
        if (addr < IW * IH) begin
            r  = addr / IW;
            c0 = addr % IW;
            for (int k = 0; k < 9; k++) begin
                for (int ch = 0; ch < OC; ch++) begin
                    src = ((r + k / 3) * PW + c0 + k % 3) * OC + ch;
                    w[(k * OC + ch) * DW +: DW] = model_mem[src];
                end
            end
        end
        return w;
    endfunction

    function automatic logic [DW-1:0] byte_of(input logic [RDW-1:0] w, input int k, input int ch);
        return w[(k * OC + ch) * DW +: DW];
    endfunction

    task automatic do_write(input int addr, input logic [DW-1:0] data, input logic pad);
        logic [31:0] a;
        a = addr;
        @(negedge clk);
        wr_en      = 1'b1;
        wr_addr    = a[WAW-1:0];
        wr_data    = data;
        is_padding = pad;
        @(posedge clk);
        #1;
        wr_en      = 1'b0;
        is_padding = 1'b0;
        if (addr < DEPTH) model_mem[addr] = pad ? 8'h00 : data;
    endtask

    task automatic issue_read(input int addr);
        logic [31:0] a;
        a = addr;
        @(negedge clk);
        rd_en   = 1'b1;
        rd_addr = a[RAW-1:0];
        sb_q.push_back(model_window(addr));
        @(posedge clk);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; is_padding = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (rd_data !== '0) begin
            bad++;
            $display("FAIL reset_rd_data: got %h want 0", rd_data);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fill();
        for (int r = 0; r < PH; r++)
            for (int c = 0; c < PW; c++)
                for (int ch = 0; ch < OC; ch++)
                    do_write((r * PW + c) * OC + ch, 8'((r * 100 + c * 10 + ch) % 256), 1'b0);
        $display("[TB] map filled with pattern");
    endtask

    task automatic test_centre_read();
        logic [DW-1:0] want [9];
        int pix [9];
        int chn [9];
        want = '{8'h6E, 8'h6F, 8'h70, 8'hDC, 8'hDD, 8'hDE, 8'h4A, 8'h4B, 8'h4C};
        pix  = '{0, 0, 0, 4, 4, 4, 8, 8, 8};
        chn  = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
        issue_read(6);
        exp_win = sb_q.pop_front();
        total++;
        if (rd_data !== exp_win) begin
            bad++;
            $display("FAIL centre_window: got %h want %h", rd_data, exp_win);
        end
        for (int i = 0; i < 9; i++) begin
            total++;
            if (byte_of(rd_data, pix[i], chn[i]) !== want[i]) begin
                bad++;
                $display("FAIL centre_p%0d_c%0d: got %h want %h", pix[i], chn[i],
                         byte_of(rd_data, pix[i], chn[i]), want[i]);
            end
        end
        held = exp_win;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rd_addr = 5'(i * 7);
            @(posedge clk);
            #1;
            total++;
            if (rd_data !== held) begin
                bad++;
                $display("FAIL hold_cycle%0d: got %h want %h", i, rd_data, held);
            end
        end
    endtask

    task automatic test_corners();
        issue_read(0);
        exp_win = sb_q.pop_front();
        total++;
        if (rd_data !== exp_win) begin
            bad++;
            $display("FAIL corner0_window: got %h want %h", rd_data, exp_win);
        end
        total++;
        if ({byte_of(rd_data, 0, 0), byte_of(rd_data, 0, 1), byte_of(rd_data, 0, 2)} !== 24'h000102) begin
            bad++;
            $display("FAIL corner0_p0: got %h want 000102",
                     {byte_of(rd_data, 0, 0), byte_of(rd_data, 0, 1), byte_of(rd_data, 0, 2)});
        end
        total++;
        if ({byte_of(rd_data, 8, 0), byte_of(rd_data, 8, 1), byte_of(rd_data, 8, 2)} !== 24'hDCDDDE) begin
            bad++;
            $display("FAIL corner0_p8: got %h want dcddde",
                     {byte_of(rd_data, 8, 0), byte_of(rd_data, 8, 1), byte_of(rd_data, 8, 2)});
        end
        issue_read(24);
        exp_win = sb_q.pop_front();
        total++;
        if (rd_data !== exp_win) begin
            bad++;
            $display("FAIL corner24_window: got %h want %h", rd_data, exp_win);
        end
        total++;
        if ({byte_of(rd_data, 8, 0), byte_of(rd_data, 8, 1), byte_of(rd_data, 8, 2)} !== 24'h949596) begin
            bad++;
            $display("FAIL corner24_p8: got %h want 949596",
                     {byte_of(rd_data, 8, 0), byte_of(rd_data, 8, 1), byte_of(rd_data, 8, 2)});
        end
    endtask

    task automatic test_padding_write();
        do_write(24, 8'hFF, 1'b1);
        issue_read(6);
        exp_win = sb_q.pop_front();
        total++;
        if (rd_data !== exp_win) begin
            bad++;
            $display("FAIL padding_window: got %h want %h", rd_data, exp_win);
        end
        total++;
        if ({byte_of(rd_data, 0, 0), byte_of(rd_data, 0, 1), byte_of(rd_data, 0, 2)} !== 24'h006F70) begin
            bad++;
            $display("FAIL padding_p0: got %h want 006f70",
                     {byte_of(rd_data, 0, 0), byte_of(rd_data, 0, 1), byte_of(rd_data, 0, 2)});
        end
    endtask

    task automatic test_reset_retention();
        issue_read(6);
        exp_win = sb_q.pop_front();
        total++;
        if (rd_data !== exp_win) begin
            bad++;
            $display("FAIL pre_reset_read: got %h want %h", rd_data, exp_win);
        end
        // A write and a read attempted under reset must both be ignored.
        @(negedge clk);
        rst = 1'b1; wr_en = 1'b1; wr_addr = 8'd30; wr_data = 8'hAA;
        rd_en = 1'b1; rd_addr = 5'd6;
        @(posedge clk);
        #1;
        total++;
        if (rd_data !== '0) begin
            bad++;
            $display("FAIL reset_pulse_clear: got %h want 0", rd_data);
        end
        @(negedge clk);
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        issue_read(6);
        exp_win = sb_q.pop_front();
        total++;
        if (rd_data !== exp_win) begin
            bad++;
            $display("FAIL post_reset_retained: got %h want %h", rd_data, exp_win);
        end
    endtask

    task automatic test_out_of_range();
        int addrs [3];
        addrs = '{0, 12, 24};
        issue_read(25);
        exp_win = sb_q.pop_front();
        total++;
        if (rd_data !== exp_win) begin
            bad++;
            $display("FAIL rd_addr25_zero: got %h want %h", rd_data, exp_win);
        end
        do_write(150, 8'h55, 1'b0);
        for (int i = 0; i < 3; i++) begin
            issue_read(addrs[i]);
            exp_win = sb_q.pop_front();
            total++;
            if (rd_data !== exp_win) begin
                bad++;
                $display("FAIL wr_addr150_ignored_rd%0d: got %h want %h", addrs[i], rd_data, exp_win);
            end
        end
    endtask

    task automatic test_read_before_write();
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 8'd72; wr_data = 8'h11; is_padding = 1'b0;
        rd_en = 1'b1; rd_addr = 5'd12;
        sb_q.push_back(model_window(12));
        @(posedge clk);
        #1;
        model_mem[72] = 8'h11;
        wr_en = 1'b0; rd_en = 1'b0;
        exp_win = sb_q.pop_front();
        total++;
        if (rd_data !== exp_win) begin
            bad++;
            $display("FAIL rbw_window: got %h want %h", rd_data, exp_win);
        end
        total++;
        if (byte_of(rd_data, 4, 0) !== 8'h4A) begin
            bad++;
            $display("FAIL rbw_old_value: got %h want 4a", byte_of(rd_data, 4, 0));
        end
        issue_read(12);
        exp_win = sb_q.pop_front();
        total++;
        if (byte_of(rd_data, 4, 0) !== 8'h11 || rd_data !== exp_win) begin
            bad++;
            $display("FAIL rbw_new_value: got %h want %h", rd_data, exp_win);
        end
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < IW * IH; a++) begin
            @(negedge clk);
            rd_en   = 1'b1;
            rd_addr = 5'(a);
            sb_q.push_back(model_window(a));
            @(posedge clk);
            #1;
            exp_win = sb_q.pop_front();
            total++;
            if (rd_data !== exp_win) begin
                bad++;
                $display("FAIL b2b_rd%0d: got %h want %h", a, rd_data, exp_win);
            end
        end
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_centre_read();
        test_corners();
        test_padding_write();
        test_reset_retention();
        test_out_of_range();
        test_read_before_write();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
